// File: rtl/sprite_bank_ram_if.sv
// Sprite bank RAM bus: write port plus registered read port.
// master = draw pipeline side, slave = sprite_bank_ram.
interface sprite_bank_ram_if #(
    parameter int BANK_W = 3,
    parameter int ADDR_W = 14,
    parameter int DATA_W = 3
);
    logic              we;
    logic [BANK_W-1:0] wr_bank;
    logic [ADDR_W-1:0] write_address;
    logic [DATA_W-1:0] data_In;
    logic              rd_en;
    logic [BANK_W-1:0] rd_bank;
    logic [ADDR_W-1:0] read_address;
    logic [DATA_W-1:0] data_Out;
    logic              rd_valid;

    modport master (
        output we, wr_bank, write_address, data_In,
        output rd_en, rd_bank, read_address,
        input  data_Out, rd_valid
    );

    modport slave (
        input  we, wr_bank, write_address, data_In,
        input  rd_en, rd_bank, read_address,
        output data_Out, rd_valid
    );
endinterface

// File: rtl/sprite_bank_ram.sv
// Multi-bank sprite frame store with animation sequencer.
// Define SPRITE_RDPIPE_EN for a second output register (read latency 2).
module sprite_bank_ram #(
    parameter int NUM_BANKS = 6,
    parameter int DEPTH     = 11664,
    parameter int DATA_W    = 3,
    parameter int ADDR_W    = 14,
    parameter int FRAME_DIV = 4,
    localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    sprite_bank_ram_if.slave  bus,
    input  logic              anim_en,
    input  logic              frame_tick,
    output logic              bank_err,
    output logic [BANK_W-1:0] cur_frame
);
    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    logic [DATA_W-1:0] mem [NUM_BANKS][DEPTH];

    logic [BANK_W-1:0] rd_eff;
    logic              rd_oor;
    logic              wr_oor;
    logic [DIV_W-1:0]  div_cnt;

    logic [DATA_W-1:0] s1_data;
    logic              s1_valid;
    logic              s1_err;
    logic              wr_err;
    logic              rd_err_out;

    assign rd_eff = anim_en ? cur_frame : bus.rd_bank;
    assign rd_oor = (32'(rd_eff) >= 32'(NUM_BANKS))
                 || (32'(bus.read_address) >= 32'(DEPTH));
    assign wr_oor = (32'(bus.wr_bank) >= 32'(NUM_BANKS))
                 || (32'(bus.write_address) >= 32'(DEPTH));

    // Memory write; the read below sees pre-write contents (read-first).
    always_ff @(posedge Clk) begin
        if (bus.we && !wr_oor)
            mem[bus.wr_bank][bus.write_address] <= bus.data_In;
    end

    // First read stage; out-of-range reads still answer, with zero data.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
        end else begin
            s1_valid <= bus.rd_en;
            s1_err   <= bus.rd_en && rd_oor;
            if (bus.rd_en)
                s1_data <= rd_oor ? '0 : mem[rd_eff][bus.read_address];
        end
    end

    // Write errors flag on the edge after the strobe, never pipelined.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            wr_err <= 1'b0;
        else
            wr_err <= bus.we && wr_oor;
    end

    // Animation: step the frame every FRAME_DIV ticks while enabled.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_cnt   <= '0;
            cur_frame <= '0;
        end else if (anim_en && frame_tick) begin
            if (div_cnt == DIV_W'(FRAME_DIV - 1)) begin
                div_cnt   <= '0;
                cur_frame <= (cur_frame == BANK_W'(NUM_BANKS - 1))
                           ? '0 : cur_frame + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

`ifdef SPRITE_RDPIPE_EN
    logic [DATA_W-1:0] s2_data;
    logic              s2_valid;
    logic              s2_err;

    // Extra output stage; data holds because s1_data holds.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s2_data  <= '0;
            s2_valid <= 1'b0;
            s2_err   <= 1'b0;
        end else begin
            s2_data  <= s1_data;
            s2_valid <= s1_valid;
            s2_err   <= s1_err;
        end
    end

    assign bus.data_Out = s2_data;
    assign bus.rd_valid = s2_valid;
    assign rd_err_out   = s2_err;
`else
    assign bus.data_Out = s1_data;
    assign bus.rd_valid = s1_valid;
    assign rd_err_out   = s1_err;
`endif

    assign bank_err = rd_err_out | wr_err;
endmodule
